iqueue: RTL and testbench
=========================

Name: iqueue

Overview:
- In-order instruction queue between the decoder and the scoreboarded register file / SALU.
- Buffers decoded instructions in a circular FIFO.
- Presents the head instruction's register indices to the register file and reads back operand-availability.
- Issues the head, in order, when its required operands are available and the SALU accepts.

Parameters:
DEPTH_LOG, 3, log2 of queue depth (DEPTH = 2**DEPTH_LOG entries)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active high
rdy  input  1  global ready; low freezes all state
flush  input  1  discard all queued instructions (redirect)
dec_valid  input  1  decoder offers an instruction
dec_type  input  2  instruction type (`REG = writes rd)
dec_rd  input  5  destination register
dec_rs1  input  5  source register 1
dec_rs2  input  5  source register 2
dec_use1  input  1  instruction reads rs1
dec_use2  input  1  instruction reads rs2
dec_op  input  6  SALU operation code
dec_imm  input  32  immediate
dec_pc  input  32  instruction PC
iq_full  output  1  queue cannot accept this cycle
count  output  DEPTH_LOG+1  current occupancy
issue_rdy  output  1  head issues this cycle
type  output  2  head type
rd  output  5  head rd
rs1  output  5  head rs1
rs2  output  5  head rs2
op1_rdy  input  1  rs1 value available at register file
op2_rdy  input  1  rs2 value available at register file
alu_ready  input  1  SALU accepts an instruction this cycle
out_op  output  6  head op code
out_imm  output  32  head immediate
out_pc  output  32  head PC

Behaviour:
- Storage: DEPTH slots, each holding type, rd, rs1, rs2, use1, use2, op, imm, pc. Head/tail pointers are DEPTH_LOG bits and wrap modulo DEPTH; count is DEPTH_LOG+1 bits.
- Reset (async, rst=1): head=0, tail=0, count=0. Slot contents are don't-care.
- Outputs while in reset: iq_full=0, issue_rdy=0, count=0, all head field outputs 0.
- iq_full = (count == DEPTH). Combinational, registered-state only.
- Enqueue condition (enq) = rdy && !flush && dec_valid && !iq_full. On enq: write slot[tail], tail+1.
- Head outputs are combinational from slot[head] when count>0; when count==0 they are driven 0.
- issue_rdy = rdy && !flush && count>0 && alu_ready && (!use1 || op1_rdy) && (!use2 || op2_rdy). The use flags are those of the head.
- On issue_rdy: head+1. The register file samples issue_rdy/type/rd on the same edge.
- count update:
  - +1 on enq only
  - -1 on issue only
  - unchanged when enq and issue occur together
- Full and issuing in the same cycle: enqueue is still refused (iq_full is based on pre-edge count). Occupancy reaches DEPTH-1 after the edge.
- Empty queue: issue_rdy=0 whatever the op_rdy inputs are. With the bypass feature disabled, minimum enqueue-to-issue latency is 1 cycle.
- flush=1 (rdy high): next edge sets head=tail=0, count=0. The same-cycle enqueue is dropped and issue_rdy is forced 0.
- flush while rdy=0: ignored.
- rdy=0: no pointer or count change; issue_rdy=0; iq_full still reflects count.
- Reset asserted mid-operation: the queue empties immediately (asynchronous); no partial issue.
- Ordering: strictly in-order; a stalled head blocks all younger entries.

Optional Feature:
- Macro: IQUEUE_BYPASS_EN.
- Defined, when count==0 and dec_valid:
  - Head outputs mux to the dec_* fields; use1/use2 come from dec_use1/dec_use2.
  - If the issue condition holds, the instruction issues in the same cycle and is not written; tail and count are unchanged.
  - Otherwise it is enqueued normally.
  - Zero-cycle latency through an empty queue.
- Undefined: no bypass path; behaviour exactly as above.

Test Plan:
- Reset then enqueue 8 instructions (DEPTH_LOG=3) with alu_ready=0 -> count=8, iq_full=1. A 9th dec_valid is refused, count stays 8.
- Full queue, alu_ready=1, op1_rdy=op2_rdy=1, dec_valid=1 for one cycle -> one issue, no enqueue, count=7. The next cycle accepts.
- Head pc=0x100 with use1=1 and rs1=5; op1_rdy=0 for 3 cycles then 1 -> issue_rdy low for 3 cycles, then high, with rs1=5 and out_pc=0x100. Younger entry pc=0x104 issues only afterwards.
- Enqueue 12 and issue 12 interleaved -> pointers wrap; issued PCs appear in exact enqueue order; count returns to 0.
- count=4, flush=1 with dec_valid=1 -> next cycle count=0, issue_rdy=0; the flushed-cycle instruction never issues.
- With IQUEUE_BYPASS_EN: empty queue, dec_valid, operands ready, alu_ready=1 -> issue_rdy=1 the same cycle, count remains 0. Without the macro: issue happens the next cycle, count=1 in between.

Source files
------------

// File: rtl/iqueue_if.sv
// ---------------------------------------------------------------------------
// iqueue_if: bundle of the instruction-queue handshake and data signals.
//
// Decoder side (into the queue):
//   rdy        global ready; low freezes all queue state
//   flush      discard everything queued (redirect)
//   dec_*      decoded instruction offered by the decoder (dec_valid qualifies)
// Register file / SALU side:
//   op1_rdy    rs1 value available      (into the queue)
//   op2_rdy    rs2 value available      (into the queue)
//   alu_ready  SALU accepts this cycle  (into the queue)
//   iq_full    queue cannot accept this cycle
//   count      current occupancy
//   issue_rdy  head issues this cycle
//   ins_type, rd, rs1, rs2, out_op, out_imm, out_pc   head instruction fields
//                                   (ins_type because 'type' is a keyword)
//
// master: the environment (decoder, register file, SALU).
// slave:  the queue itself.
// ---------------------------------------------------------------------------
interface iqueue_if #(
  parameter int unsigned DEPTH_LOG = 3
);
  logic                 rdy;
  logic                 flush;
  logic                 dec_valid;
  logic [1:0]           dec_type;
  logic [4:0]           dec_rd;
  logic [4:0]           dec_rs1;
  logic [4:0]           dec_rs2;
  logic                 dec_use1;
  logic                 dec_use2;
  logic [5:0]           dec_op;
  logic [31:0]          dec_imm;
  logic [31:0]          dec_pc;
  logic                 iq_full;
  logic [DEPTH_LOG:0]   count;
  logic                 issue_rdy;
  logic [1:0]           ins_type;
  logic [4:0]           rd;
  logic [4:0]           rs1;
  logic [4:0]           rs2;
  logic                 op1_rdy;
  logic                 op2_rdy;
  logic                 alu_ready;
  logic [5:0]           out_op;
  logic [31:0]          out_imm;
  logic [31:0]          out_pc;

  modport master (
    output rdy, flush, dec_valid, dec_type, dec_rd, dec_rs1, dec_rs2,
           dec_use1, dec_use2, dec_op, dec_imm, dec_pc,
           op1_rdy, op2_rdy, alu_ready,
    input  iq_full, count, issue_rdy, ins_type, rd, rs1, rs2,
           out_op, out_imm, out_pc
  );

  modport slave (
    input  rdy, flush, dec_valid, dec_type, dec_rd, dec_rs1, dec_rs2,
           dec_use1, dec_use2, dec_op, dec_imm, dec_pc,
           op1_rdy, op2_rdy, alu_ready,
    output iq_full, count, issue_rdy, ins_type, rd, rs1, rs2,
           out_op, out_imm, out_pc
  );
endinterface

// File: rtl/iqueue.sv
// ---------------------------------------------------------------------------
// iqueue: in-order instruction queue between the decoder and the scoreboarded
// register file / SALU.
//
// Decoded instructions are buffered in a circular FIFO of 2**DEPTH_LOG slots.
// The head's register indices are presented to the register file, which
// answers with operand availability (op1_rdy/op2_rdy). The head issues, in
// order, once the operands it actually uses are available and the SALU
// accepts. A stalled head blocks every younger entry.
//
// Ports:
//   clk    clock, rising edge
//   rst    asynchronous reset, active high (queue empties immediately)
//   iq_io  iqueue_if.slave bundle (decoder input, head outputs, handshakes)
//
// Optional feature (macro IQUEUE_BYPASS_EN):
//   When the queue is empty and the decoder offers an instruction, the head
//   outputs show the decoder's fields directly. If the issue condition holds
//   the instruction issues in that same cycle and is never written; otherwise
//   it is enqueued as usual. Without the macro there is no bypass path and the
//   minimum enqueue-to-issue latency is one cycle.
// ---------------------------------------------------------------------------
module iqueue #(
  parameter int unsigned DEPTH_LOG = 3
) (
  input logic     clk,
  input logic     rst,
  iqueue_if.slave iq_io
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG;
  localparam int unsigned CntW  = DEPTH_LOG + 1;

  localparam logic [DEPTH_LOG-1:0] PtrOne  = 1;
  localparam logic [CntW-1:0]      CntOne  = 1;
  localparam logic [CntW-1:0]      CntFull = CntW'(DEPTH);

  typedef struct packed {
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use1;
    logic        use2;
    logic [5:0]  op;
    logic [31:0] imm;
    logic [31:0] pc;
  } slot_t;

  // Slot storage carries no reset: contents are only observed when count > 0.
  slot_t                slot_q [DEPTH];

  logic [DEPTH_LOG-1:0] head_q, head_d;
  logic [DEPTH_LOG-1:0] tail_q, tail_d;
  logic [CntW-1:0]      count_q, count_d;

  slot_t dec_slot;
  slot_t hd;
  logic  not_empty;
  logic  full;
  logic  run;
  logic  enq;
  logic  hd_valid;
  logic  ops_ok;
  logic  issue;
  logic  pop;
  logic  enq_wr;
  logic  byp;

  // -------------------------------------------------------------------------
  // Decoder record and status
  // -------------------------------------------------------------------------
  assign dec_slot = '{
    typ:  iq_io.dec_type,
    rd:   iq_io.dec_rd,
    rs1:  iq_io.dec_rs1,
    rs2:  iq_io.dec_rs2,
    use1: iq_io.dec_use1,
    use2: iq_io.dec_use2,
    op:   iq_io.dec_op,
    imm:  iq_io.dec_imm,
    pc:   iq_io.dec_pc
  };

  assign not_empty = (count_q != '0);
  // Full is based on pre-edge occupancy only, so a full queue that issues this
  // cycle still refuses the offered instruction.
  assign full      = (count_q == CntFull);
  assign run       = iq_io.rdy && !iq_io.flush;
  assign enq       = run && iq_io.dec_valid && !full;

`ifdef IQUEUE_BYPASS_EN
  // Reset gating keeps the head outputs at zero while rst is held.
  assign byp = !not_empty && iq_io.dec_valid && !rst;
`else
  assign byp = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Head selection and issue decision
  // -------------------------------------------------------------------------
  always_comb begin
    hd       = '0;
    hd_valid = 1'b0;
    if (not_empty) begin
      hd       = slot_q[head_q];
      hd_valid = 1'b1;
    end else if (byp) begin
      hd       = dec_slot;
      hd_valid = 1'b1;
    end
  end

  assign ops_ok = (!hd.use1 || iq_io.op1_rdy) && (!hd.use2 || iq_io.op2_rdy);
  assign issue  = run && hd_valid && iq_io.alu_ready && ops_ok;

  // Only a stored head advances the head pointer; a bypassed issue never
  // touched the storage and must not be written either.
  assign pop    = issue && not_empty;
  assign enq_wr = enq && !(byp && issue);

  // -------------------------------------------------------------------------
  // Pointer / occupancy next state
  // -------------------------------------------------------------------------
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (iq_io.rdy) begin
      if (iq_io.flush) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (enq_wr) begin
          tail_d = tail_q + PtrOne;
        end
        if (pop) begin
          head_d = head_q + PtrOne;
        end
        case ({enq_wr, pop})
          2'b10:   count_d = count_q + CntOne;
          2'b01:   count_d = count_q - CntOne;
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_wr) begin
      slot_q[tail_q] <= dec_slot;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign iq_io.iq_full   = full;
  assign iq_io.count     = count_q;
  assign iq_io.issue_rdy = issue;
  assign iq_io.ins_type  = hd.typ;
  assign iq_io.rd        = hd.rd;
  assign iq_io.rs1       = hd.rs1;
  assign iq_io.rs2       = hd.rs2;
  assign iq_io.out_op    = hd.op;
  assign iq_io.out_imm   = hd.imm;
  assign iq_io.out_pc    = hd.pc;

endmodule

// File: tb/tb_iqueue.sv
module tb_iqueue;

  localparam int unsigned DL    = 3;
  localparam int          Depth = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iqueue_if #(.DEPTH_LOG(DL)) iq ();

  iqueue #(.DEPTH_LOG(DL)) dut (
    .clk   (clk),
    .rst   (rst),
    .iq_io (iq)
  );

  typedef struct packed {
    logic        rdy;
    logic        flush;
    logic        valid;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use1;
    logic        use2;
    logic [5:0]  op;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        op1;
    logic        op2;
    logic        alu;
  } in_t;

  typedef struct packed {
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use1;
    logic        use2;
    logic [5:0]  op;
    logic [31:0] imm;
    logic [31:0] pc;
  } ins_t;

  typedef struct {
    in_t         in;
    int          cnt;
    logic        full;
    logic        iss;
    logic [31:0] pc;
  } vec_t;

  // Reference model: the queue contents in program order.
  ins_t        mq[$];
  logic [31:0] issued[$];
  vec_t        tbl[$];
  int          nvec = 0;
  int          nbad = 0;
  bit          byp_en;

  // Pre-edge samples of the most recent apply().
  int          s_cnt;
  logic        s_full, s_iss;
  logic [31:0] s_pc;
  logic [4:0]  s_rs1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic in_t mk(logic [31:0] pc, logic valid, logic alu, logic use1 = 1'b0,
                             logic [4:0] rs1 = 5'd0, logic op1 = 1'b1, logic rdy = 1'b1,
                             logic flush = 1'b0);
    in_t v;
    v.rdy   = rdy;
    v.flush = flush;
    v.valid = valid;
    v.typ   = pc[3:2];
    v.rd    = pc[8:4];
    v.rs1   = rs1;
    v.rs2   = pc[13:9];
    v.use1  = use1;
    v.use2  = 1'b0;
    v.op    = pc[7:2];
    v.imm   = ~pc;
    v.pc    = pc;
    v.op1   = op1;
    v.op2   = 1'b1;
    v.alu   = alu;
    return v;
  endfunction

  function automatic ins_t to_ins(in_t v);
    ins_t r;
    r.typ  = v.typ;
    r.rd   = v.rd;
    r.rs1  = v.rs1;
    r.rs2  = v.rs2;
    r.use1 = v.use1;
    r.use2 = v.use2;
    r.op   = v.op;
    r.imm  = v.imm;
    r.pc   = v.pc;
    return r;
  endfunction

  task automatic drive(input in_t v);
    iq.rdy       = v.rdy;
    iq.flush     = v.flush;
    iq.dec_valid = v.valid;
    iq.dec_type  = v.typ;
    iq.dec_rd    = v.rd;
    iq.dec_rs1   = v.rs1;
    iq.dec_rs2   = v.rs2;
    iq.dec_use1  = v.use1;
    iq.dec_use2  = v.use2;
    iq.dec_op    = v.op;
    iq.dec_imm   = v.imm;
    iq.dec_pc    = v.pc;
    iq.op1_rdy   = v.op1;
    iq.op2_rdy   = v.op2;
    iq.alu_ready = v.alu;
  endtask

  // One clock: drive on the falling edge, compare against the model before the
  // rising edge, then advance the model with the rules of the queue.
  task automatic apply(input in_t v);
    ins_t h;
    logic hv, iss;
    int   n;
    @(negedge clk);
    drive(v);
    #2;
    n  = mq.size();
    h  = '0;
    hv = 1'b0;
    if (n > 0) begin
      h  = mq[0];
      hv = 1'b1;
    end else if (byp_en && v.valid) begin
      h  = to_ins(v);
      hv = 1'b1;
    end
    iss = hv && v.rdy && !v.flush && v.alu && (!h.use1 || v.op1) && (!h.use2 || v.op2);

    s_cnt  = int'(iq.count);
    s_full = iq.iq_full;
    s_iss  = iq.issue_rdy;
    s_pc   = iq.out_pc;
    s_rs1  = iq.rs1;
    if (iq.issue_rdy) issued.push_back(iq.out_pc);

    chk("count",     32'(iq.count),     32'(n));
    chk("iq_full",   32'(iq.iq_full),   32'(n == Depth));
    chk("issue_rdy", 32'(iq.issue_rdy), 32'(iss));
    chk("type",      32'(iq.ins_type),  32'(h.typ));
    chk("rd",        32'(iq.rd),        32'(h.rd));
    chk("rs1",       32'(iq.rs1),       32'(h.rs1));
    chk("rs2",       32'(iq.rs2),       32'(h.rs2));
    chk("out_op",    32'(iq.out_op),    32'(h.op));
    chk("out_imm",   iq.out_imm,        h.imm);
    chk("out_pc",    iq.out_pc,         h.pc);

    @(posedge clk);
    if (rst) begin
      mq.delete();
    end else if (v.rdy) begin
      if (v.flush) begin
        mq.delete();
      end else begin
        if (iss && n > 0) void'(mq.pop_front());
        // Accepted unless full; a same-cycle bypass issue is never stored.
        if (v.valid && n < Depth && !(iss && n == 0)) mq.push_back(to_ins(v));
      end
    end
  endtask

  initial begin
    in_t v;
    int  e;
    int  cyc;

`ifdef IQUEUE_BYPASS_EN
    byp_en = 1'b1;
`else
    byp_en = 1'b0;
`endif

    // ---- reset: outputs held at zero even with an instruction offered ----
    rst = 1'b1;
    drive(mk(32'h100, 1'b1, 1'b1));
    #3;
    chk("rst_count", 32'(iq.count),     32'd0);
    chk("rst_full",  32'(iq.iq_full),   32'd0);
    chk("rst_issue", 32'(iq.issue_rdy), 32'd0);
    chk("rst_pc",    iq.out_pc,         32'd0);
    chk("rst_rd",    32'(iq.rd),        32'd0);
    @(negedge clk);
    drive(mk(32'h0, 1'b0, 1'b0));
    rst = 1'b0;

    // ---- table: fill, refuse when full, issue-while-full, flush, rdy=0 ----
    for (int i = 0; i < 8; i++) begin
      tbl.push_back('{mk(32'h100 + 32'(4 * i), 1'b1, 1'b0), i, 1'b0, 1'b0,
                      (i == 0) ? (byp_en ? 32'h100 : 32'h0) : 32'h100});
    end
    tbl.push_back('{mk(32'h200, 1'b1, 1'b0), 8, 1'b1, 1'b0, 32'h100});
    tbl.push_back('{mk(32'h200, 1'b1, 1'b0), 8, 1'b1, 1'b0, 32'h100});
    tbl.push_back('{mk(32'h200, 1'b1, 1'b1), 8, 1'b1, 1'b1, 32'h100});
    tbl.push_back('{mk(32'h200, 1'b1, 1'b0), 7, 1'b0, 1'b0, 32'h104});
    tbl.push_back('{mk(32'h0,   1'b0, 1'b1), 8, 1'b1, 1'b1, 32'h104});
    tbl.push_back('{mk(32'h300, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1),
                    7, 1'b0, 1'b0, 32'h108});
    tbl.push_back('{mk(32'h0,   1'b0, 1'b1), 0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{mk(32'h400, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0),
                    0, 1'b0, 1'b0, byp_en ? 32'h400 : 32'h0});
    tbl.push_back('{mk(32'h404, 1'b1, 1'b1), 0, 1'b0, byp_en, byp_en ? 32'h404 : 32'h0});
    tbl.push_back('{mk(32'h0,   1'b0, 1'b1), byp_en ? 0 : 1, 1'b0, !byp_en,
                    byp_en ? 32'h0 : 32'h404});
    tbl.push_back('{mk(32'h0,   1'b0, 1'b0), 0, 1'b0, 1'b0, 32'h0});

    foreach (tbl[i]) begin
      apply(tbl[i].in);
      chk($sformatf("tbl%0d_count", i), 32'(s_cnt), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_full", i),  32'(s_full), 32'(tbl[i].full));
      chk($sformatf("tbl%0d_issue", i), 32'(s_iss), 32'(tbl[i].iss));
      chk($sformatf("tbl%0d_pc", i),    s_pc, tbl[i].pc);
    end

    // ---- operand stall: head blocked on rs1, younger entry waits ----
    apply(mk(32'h100, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0));
    apply(mk(32'h104, 1'b1, 1'b0));
    for (int k = 0; k < 3; k++) begin
      apply(mk(32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0));
      chk("stall_issue", 32'(s_iss), 32'd0);
      chk("stall_rs1",   32'(s_rs1), 32'd5);
      chk("stall_pc",    s_pc,       32'h100);
    end
    apply(mk(32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1));
    chk("unstall_issue", 32'(s_iss), 32'd1);
    chk("unstall_rs1",   32'(s_rs1), 32'd5);
    chk("unstall_pc",    s_pc,       32'h100);
    apply(mk(32'h0, 1'b0, 1'b1));
    chk("younger_issue", 32'(s_iss), 32'd1);
    chk("younger_pc",    s_pc,       32'h104);

    // ---- 12 in, 12 out interleaved: pointers wrap, order preserved ----
    issued.delete();
    e   = 0;
    cyc = 0;
    while (issued.size() < 12 && cyc < 80) begin
      apply(mk(32'h500 + 32'(4 * e), e < 12, (cyc % 2 == 1) || e >= 12));
      if (e < 12) e++;
      cyc++;
    end
    chk("wrap_issued", 32'(issued.size()), 32'd12);
    foreach (issued[i]) begin
      chk($sformatf("wrap_order%0d", i), issued[i], 32'h500 + 32'(4 * i));
    end
    apply(mk(32'h0, 1'b0, 1'b0));
    chk("wrap_empty", 32'(s_cnt), 32'd0);

    // ---- flush at count 4 with an instruction offered ----
    for (int i = 0; i < 4; i++) apply(mk(32'h600 + 32'(4 * i), 1'b1, 1'b0));
    issued.delete();
    apply(mk(32'h700, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1));
    chk("flush_cnt_pre", 32'(s_cnt), 32'd4);
    chk("flush_issue",   32'(s_iss), 32'd0);
    for (int k = 0; k < 3; k++) apply(mk(32'h0, 1'b0, 1'b1));
    chk("flush_cnt_post", 32'(s_cnt), 32'd0);
    chk("flush_no_issue", 32'(issued.size()), 32'd0);

    // ---- asynchronous reset in the middle of operation ----
    for (int i = 0; i < 3; i++) apply(mk(32'h800 + 32'(4 * i), 1'b1, 1'b0));
    @(negedge clk);
    drive(mk(32'h900, 1'b1, 1'b1));
    rst = 1'b1;
    #2;
    chk("arst_count", 32'(iq.count),     32'd0);
    chk("arst_issue", 32'(iq.issue_rdy), 32'd0);
    chk("arst_full",  32'(iq.iq_full),   32'd0);
    chk("arst_pc",    iq.out_pc,         32'd0);
    @(posedge clk);
    mq.delete();
    @(negedge clk);
    drive(mk(32'h0, 1'b0, 1'b0));
    rst = 1'b0;
    apply(mk(32'h0, 1'b0, 1'b1));

    // ---- randomized traffic against the model ----
    for (int k = 0; k < 600; k++) begin
      v = mk($urandom, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5,
             1'($urandom_range(0, 1)), 5'($urandom), $urandom_range(0, 9) < 7,
             $urandom_range(0, 9) < 9, $urandom_range(0, 99) < 3);
      v.use2 = 1'($urandom_range(0, 1));
      v.op2  = $urandom_range(0, 9) < 7;
      apply(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
